// File: rtl/lite_write_ctrl.sv
// rtl/lite_write_ctrl.sv - AXI4-Lite master programming DMA MM2S (DMACR, SA, LENGTH).
// Optional per-write timeout abort enabled by LITE_WRITE_TIMEOUT_EN.
module lite_write_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [25:0] length,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [9:0]  m_axi_lite_awaddr,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic [3:0]  m_axi_lite_wstrb,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready
);

  typedef enum logic [2:0] {IDLE, ISSUE, RESP, DONE, ERR} state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n, idx_inc;
  logic [31:0] src_q, src_n;
  logic [25:0] len_q, len_n;
  logic [9:0]  awaddr_n;
  logic [31:0] wdata_n;
  logic        awvalid_n, wvalid_n, bready_n, done_n, err_n, busy_n;
  logic [1:0]  err_code_n;
`ifdef LITE_WRITE_TIMEOUT_EN
  logic [31:0] cnt, cnt_n;
`endif

  assign m_axi_lite_wstrb = 4'hF;
  assign idx_inc = idx + 2'd1;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    src_n      = src_q;
    len_n      = len_q;
    awaddr_n   = m_axi_lite_awaddr;
    wdata_n    = m_axi_lite_wdata;
    awvalid_n  = m_axi_lite_awvalid;
    wvalid_n   = m_axi_lite_wvalid;
    bready_n   = m_axi_lite_bready;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_code_n = err_code;
`ifdef LITE_WRITE_TIMEOUT_EN
    cnt_n      = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          src_n      = src_addr;
          len_n      = length;
          err_code_n = 2'b00;
          if (length == 26'd0) begin
            state_n    = ERR;
            err_n      = 1'b1;
            err_code_n = 2'b10;
          end else begin
            state_n   = ISSUE;
            idx_n     = 2'd0;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = 10'h000;
            wdata_n   = 32'h0000_0001;
          end
        end
      end
      ISSUE: begin
        // each channel drops its valid independently once its own handshake is seen
        if (m_axi_lite_awvalid && m_axi_lite_awready) awvalid_n = 1'b0;
        if (m_axi_lite_wvalid && m_axi_lite_wready)   wvalid_n  = 1'b0;
        if ((!m_axi_lite_awvalid || m_axi_lite_awready) &&
            (!m_axi_lite_wvalid || m_axi_lite_wready)) begin
          state_n  = RESP;
          bready_n = 1'b1;
        end
      end
      RESP: begin
        if (m_axi_lite_bvalid && m_axi_lite_bready) begin
          bready_n = 1'b0;
          if (m_axi_lite_bresp != 2'b00) begin
            state_n    = ERR;
            err_n      = 1'b1;
            err_code_n = 2'b01;
          end else if (idx == 2'd2) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = ISSUE;
            idx_n     = idx_inc;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            if (idx_inc == 2'd1) begin
              awaddr_n = 10'h018;
              wdata_n  = src_q;
            end else begin
              awaddr_n = 10'h028;
              wdata_n  = {6'd0, len_q};
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef LITE_WRITE_TIMEOUT_EN
    if (state == ISSUE || state == RESP) begin
      if (cnt == TIMEOUT_CYCLES) begin
        state_n    = ERR;
        awvalid_n  = 1'b0;
        wvalid_n   = 1'b0;
        bready_n   = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b1;
        err_code_n = 2'b11;
      end else begin
        cnt_n = cnt + 32'd1;
      end
    end
    if (state_n == ISSUE && state != ISSUE) cnt_n = 32'd0;
`endif
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      idx                <= 2'd0;
      src_q              <= 32'd0;
      len_q              <= 26'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      err_code           <= 2'b00;
      m_axi_lite_awaddr  <= 10'd0;
      m_axi_lite_awvalid <= 1'b0;
      m_axi_lite_wdata   <= 32'd0;
      m_axi_lite_wvalid  <= 1'b0;
      m_axi_lite_bready  <= 1'b0;
`ifdef LITE_WRITE_TIMEOUT_EN
      cnt                <= 32'd0;
`endif
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      src_q              <= src_n;
      len_q              <= len_n;
      busy               <= busy_n;
      done               <= done_n;
      err                <= err_n;
      err_code           <= err_code_n;
      m_axi_lite_awaddr  <= awaddr_n;
      m_axi_lite_awvalid <= awvalid_n;
      m_axi_lite_wdata   <= wdata_n;
      m_axi_lite_wvalid  <= wvalid_n;
      m_axi_lite_bready  <= bready_n;
`ifdef LITE_WRITE_TIMEOUT_EN
      cnt                <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_lite_write_ctrl.sv
// tb/tb_lite_write_ctrl.sv - scoreboard bench for lite_write_ctrl with a configurable AXI-Lite slave.
module tb_lite_write_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr;
  logic [25:0] length;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [9:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  lite_write_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .length(length),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb), .m_axi_lite_wvalid(wvalid),
    .m_axi_lite_wready(wready), .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid),
    .m_axi_lite_bready(bready)
  );

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 err
    logic [9:0]  addr;
    logic [31:0] data;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = 0; e.addr = a; e.data = d; e.code = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_ev(input int k, input logic [1:0] c);
    exp_t e;
    e.kind = k; e.addr = '0; e.data = '0; e.code = c;
    exp_q.push_back(e);
  endtask

  // slave configuration
  int         aw_delay = 0;
  int         w_delay = 0;
  logic [1:0] resp_tab [3];
  logic       b_en = 1'b1;

  initial begin
    logic aw_fire, w_fire, b_fire, aw_got, w_got;
    int   aw_wait, w_wait, widx;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; widx = 0;
    forever begin
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      @(posedge clk); #1;
      if (rst || !busy) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0; widx = 0;
      end else begin
        if (aw_fire) aw_got = 1;
        if (w_fire)  w_got = 1;
        if (b_fire)  bvalid = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0;
          bvalid = b_en;
          bresp  = (widx < 3) ? resp_tab[widx] : 2'b00;
          widx++;
        end
        aw_wait = awvalid ? aw_wait + 1 : 0;
        w_wait  = wvalid ? w_wait + 1 : 0;
        awready = awvalid && (aw_wait > aw_delay);
        wready  = wvalid && (w_wait > w_delay);
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a write, done or err
  initial begin
    logic        have_a, have_w;
    logic [9:0]  cap_a;
    logic [31:0] cap_d;
    exp_t        e;
    have_a = 0; have_w = 0; cap_a = '0; cap_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_a = 0; have_w = 0;
      end else begin
        if (awvalid && awready) begin cap_a = awaddr; have_a = 1; end
        if (wvalid && wready)   begin cap_d = wdata;  have_w = 1; end
        if (have_a && have_w) begin
          have_a = 0; have_w = 0;
          check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_kind", 32'd0, e.kind);
            check("wr_addr", {22'd0, cap_a}, {22'd0, e.addr});
            check("wr_data", cap_d, e.data);
          end
        end
        if (done) begin
          check("done_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_kind", 32'd1, e.kind);
          end
        end
        if (err) begin
          check("err_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("err_kind", 32'd2, e.kind);
            check("err_code", {30'd0, err_code}, {30'd0, e.code});
          end
        end
      end
    end
  end

  // observations from the last sequence
  int   done_cyc, err_cyc, idle_cyc, first_bready, aw_run, w_run;
  logic overlap, aw_seen, w_seen, aw_unstable, bready_last;
  logic [1:0] code_c1;

  task automatic go(input logic [31:0] s, input logic [25:0] l, input int mid_start, input int rst_cyc);
    logic       aw_end, w_end, prev_aw;
    logic [9:0] prev_addr;
    done_cyc = 0; err_cyc = 0; idle_cyc = 0; first_bready = 0; aw_run = 0; w_run = 0;
    overlap = 0; aw_seen = 0; w_seen = 0; aw_unstable = 0; bready_last = 0; code_c1 = 2'b00;
    aw_end = 0; w_end = 0; prev_aw = 0; prev_addr = '0;
    @(posedge clk); #1;
    src_addr = s; length = l; start = 1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = (c == mid_start);
      if (start) length = 26'd0;
      if (c == 1) code_c1 = err_code;
      if (done && done_cyc == 0) done_cyc = c;
      if (err && err_cyc == 0) err_cyc = c;
      if (bready && first_bready == 0) first_bready = c;
      if (bready && (awvalid || wvalid)) overlap = 1;
      if (awvalid) aw_seen = 1;
      if (wvalid) w_seen = 1;
      if (awvalid && !aw_end) aw_run++;
      if (!awvalid && aw_run > 0) aw_end = 1;
      if (wvalid && !w_end) w_run++;
      if (!wvalid && w_run > 0) w_end = 1;
      if (awvalid && prev_aw && awaddr != prev_addr) aw_unstable = 1;
      prev_aw = awvalid; prev_addr = awaddr;
      bready_last = bready;
      if (!busy) begin idle_cyc = c; break; end
      if (c == rst_cyc) break;
    end
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; src_addr = '0; length = '0;
    for (int i = 0; i < 3; i++) resp_tab[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {26'd0, awvalid, wvalid, bready, busy, done, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_awaddr", {22'd0, awaddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", {28'd0, wstrb}, 32'hF);
    rst = 0;

    // always-ready slave
    push_wr(10'h000, 32'h0000_0001);
    push_wr(10'h018, 32'h1000_0000);
    push_wr(10'h028, 32'h0000_1000);
    push_ev(1, 2'b00);
    go(32'h1000_0000, 26'd4096, 0, 0);
    check("t1_done_cyc", done_cyc, 7);
    check("t1_idle_cyc", idle_cyc, 8);
    check("t1_no_err", err_cyc, 0);
    check("t1_no_overlap", {31'd0, overlap}, 0);

    // awready delayed 3 cycles
    aw_delay = 3;
    push_wr(10'h000, 32'h0000_0001);
    push_wr(10'h018, 32'hA5A5_0004);
    push_wr(10'h028, 32'h0000_000C);
    push_ev(1, 2'b00);
    go(32'hA5A5_0004, 26'd12, 0, 0);
    check("t2_aw_run", aw_run, 4);
    check("t2_w_run", w_run, 1);
    check("t2_first_bready", first_bready, 5);
    check("t2_aw_stable", {31'd0, aw_unstable}, 0);
    check("t2_no_overlap", {31'd0, overlap}, 0);
    check("t2_done_cyc", done_cyc, 16);
    aw_delay = 0;

    // SLVERR on write index 1
    resp_tab[1] = 2'b10;
    push_wr(10'h000, 32'h0000_0001);
    push_wr(10'h018, 32'h2000_0040);
    push_ev(2, 2'b01);
    go(32'h2000_0040, 26'd64, 0, 0);
    check("t3_err_cyc", err_cyc, 5);
    check("t3_no_done", done_cyc, 0);
    check("t3_code_held", {30'd0, err_code}, 32'd1);
    check("t3_idle_cyc", idle_cyc, 6);
    resp_tab[1] = 2'b00;

    // zero length
    push_ev(2, 2'b10);
    go(32'h3000_0000, 26'd0, 0, 0);
    check("t4_err_cyc", err_cyc, 1);
    check("t4_no_axi", {30'd0, aw_seen, w_seen}, 0);
    check("t4_code_held", {30'd0, err_code}, 32'd2);

    // reset during RESP of write index 1, start pulsed while busy
    push_wr(10'h000, 32'h0000_0001);
    push_wr(10'h018, 32'h4000_0100);
    go(32'h4000_0100, 26'd256, 2, 4);
    check("t5_code_cleared", {30'd0, code_c1}, 0);
    check("t5_in_resp", {31'd0, bready_last}, 1);
    rst = 1;
    @(posedge clk); #1;
    check("t5_rst_ctrl", {26'd0, awvalid, wvalid, bready, busy, done, err}, 32'd0);
    check("t5_rst_awaddr", {22'd0, awaddr}, 32'd0);
    check("t5_rst_wdata", wdata, 32'd0);
    check("t5_rst_wstrb", {28'd0, wstrb}, 32'hF);
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_stays_idle", {31'd0, busy}, 0);

`ifdef LITE_WRITE_TIMEOUT_EN
    // bvalid never arrives
    b_en = 1'b0;
    push_wr(10'h000, 32'h0000_0001);
    push_ev(2, 2'b11);
    go(32'h5000_0000, 26'd8, 0, 0);
    check("t6_err_cyc", err_cyc, 18);
    check("t6_code", {30'd0, err_code}, 32'd3);
    check("t6_bready_low", {31'd0, bready}, 0);
    check("t6_idle_cyc", idle_cyc, 19);
    b_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
